// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory port controller: store op codes,
// address-exception codes, the default memory bound and the sequencer states.
package dm_pkg;

   localparam logic [1:0] SW = 2'b00;
   localparam logic [1:0] SB = 2'b01;
   localparam logic [1:0] SH = 2'b10;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   localparam logic [31:0] DM_END_DEF = 32'h0000_2fff;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RESP,
      MRG,
      WR,
      ERR
   } state_e;

   // Returns the exception code for a candidate access, EXC_NONE when legal.
   function automatic logic [4:0] access_exc(input logic        we,
                                             input logic [1:0]  op,
                                             input logic [31:0] addr,
                                             input logic [31:0] dm_end);
      logic bad;
      bad = (addr > dm_end);
      if (!we) begin
         bad = bad | (addr[1:0] != 2'b00);
      end else if (op == SH) begin
         bad = bad | addr[0];
      end else if (op != SB) begin
         bad = bad | (addr[1:0] != 2'b00);
      end
      if (!bad) begin
         return EXC_NONE;
      end
      return we ? EXC_ADES : EXC_ADEL;
   endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational lane merge for sub-word stores: folds right-aligned store data
// into the old memory word at the byte or half-word lane selected by the address.
module dm_byte_merge
   import dm_pkg::*;
(
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  op_i,
   input  logic [1:0]  lane_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_word_i;
      case (op_i)
         SB: begin
            case (lane_i)
               2'd0: merged_o[7:0]   = wdata_i[7:0];
               2'd1: merged_o[15:8]  = wdata_i[7:0];
               2'd2: merged_o[23:16] = wdata_i[7:0];
               2'd3: merged_o[31:24] = wdata_i[7:0];
            endcase
         end
         SH: begin
            if (lane_i[1]) begin
               merged_o[31:16] = wdata_i[15:0];
            end else begin
               merged_o[15:0] = wdata_i[15:0];
            end
         end
         SW:      merged_o = wdata_i;
         default: merged_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/dm_port_ctrl.sv
// Two-port round-robin sequencer in front of a single-port word memory; turns
// sub-word stores into read-modify-write and rejects illegal addresses up front.
module dm_port_ctrl
   import dm_pkg::*;
#(
   parameter logic [31:0] DM_END = DM_END_DEF,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [1:0]        op0,
   input  logic [1:0]        op1,
   input  logic [31:0]       addr0,
   input  logic [31:0]       addr1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [4:0]        exc_code,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_e            state_q;
   logic              last_grant_q;
   logic              we_q;
   logic [1:0]        op_q;
   logic [1:0]        lane_q;
   logic [31:0]       wdata_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              err_q;
   logic [4:0]        exc_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   logic              grant_d;
   logic              sel_we;
   logic [1:0]        sel_op;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic [4:0]        sel_exc;
   logic              sel_sub;
   logic [31:0]       merged_word;

   // With both ports requesting, the port that was not served last wins.
   always_comb begin
      grant_d   = (req0 && req1) ? ~last_grant_q : req1;
      sel_we    = grant_d ? we1    : we0;
      sel_op    = grant_d ? op1    : op0;
      sel_addr  = grant_d ? addr1  : addr0;
      sel_wdata = grant_d ? wdata1 : wdata0;
      sel_exc   = access_exc(sel_we, sel_op, sel_addr, DM_END);
      sel_sub   = sel_we && ((sel_op == SB) || (sel_op == SH));
   end

   dm_byte_merge u_merge (
      .old_word_i (mem_rdata),
      .wdata_i    (wdata_q),
      .op_i       (op_q),
      .lane_i     (lane_q),
      .merged_o   (merged_word)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         op_q         <= 2'b00;
         lane_q       <= 2'b00;
         wdata_q      <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err_q        <= 1'b0;
         exc_q        <= EXC_NONE;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err_q    <= 1'b0;
         exc_q    <= EXC_NONE;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  last_grant_q <= grant_d;
                  we_q         <= sel_we;
                  op_q         <= sel_op;
                  lane_q       <= sel_addr[1:0];
                  wdata_q      <= sel_wdata;
                  if (sel_exc != EXC_NONE) begin
                     state_q <= ERR;
                     ack0_q  <= ~grant_d;
                     ack1_q  <= grant_d;
                     err_q   <= 1'b1;
                     exc_q   <= sel_exc;
                  end else if (!sel_we || sel_sub) begin
                     state_q    <= RD;
                     mem_en_q   <= 1'b1;
                     mem_addr_q <= sel_addr[ADDR_W+1:2];
                  end else begin
                     state_q     <= WR;
                     mem_en_q    <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= sel_addr[ADDR_W+1:2];
                     mem_wdata_q <= sel_wdata;
                     ack0_q      <= ~grant_d;
                     ack1_q      <= grant_d;
                  end
               end
            end
            RD: begin
               if (!we_q) begin
                  state_q <= RESP;
                  ack0_q  <= ~last_grant_q;
                  ack1_q  <= last_grant_q;
               end else begin
                  state_q <= MRG;
               end
            end
            RESP: begin
               state_q    <= IDLE;
               mem_addr_q <= '0;
            end
            // Old word is on mem_rdata this cycle; the merged word goes out in WR.
            MRG: begin
               state_q     <= WR;
               mem_en_q    <= 1'b1;
               mem_we_q    <= 1'b1;
               mem_wdata_q <= merged_word;
               ack0_q      <= ~last_grant_q;
               ack1_q      <= last_grant_q;
            end
            WR: begin
               state_q     <= IDLE;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
            end
            ERR: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign err       = err_q;
   assign exc_code  = exc_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   // Read data arrives the cycle after the read strobe, which is the RESP cycle.
   assign rdata     = (state_q == RESP) ? mem_rdata : '0;

endmodule

// File: tb/tb_dm_port_ctrl.sv
// Directed bench for dm_port_ctrl: a vector table of single transactions on a
// simple word memory, plus arbitration, reset-abort and lane-merge sequences.
module tb_dm_port_ctrl;
   import dm_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [1:0]  op0, op1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err, mem_en, mem_we;
   logic [31:0] rdata, mem_wdata;
   logic [31:0] mem_rdata;
   logic [4:0]  exc_code;
   logic [11:0] mem_addr;

   logic [31:0] m_old, m_wd, m_out;
   logic [1:0]  m_op, m_lane;

   logic [31:0] mem [0:4095];
   logic        load_mem;
   bit          pend0, pend1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dm_port_ctrl dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .exc_code(exc_code),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dm_byte_merge u_mrg (
      .old_word_i(m_old), .wdata_i(m_wd), .op_i(m_op), .lane_i(m_lane), .merged_o(m_out)
   );

   // Synchronous single-port memory: read data one cycle after the strobe.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
         mem[8]      <= 32'hCAFE_F00D;
         mem[12'hbff] <= 32'hA0B0_C0D0;
         mem_rdata   <= 32'h0;
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr];
      end
   end

   // Requesters must hold req until their ack.
   always @(posedge clk) begin
      if (!reset) begin
         pend0 <= 1'b0;
         pend1 <= 1'b0;
      end else begin
         assert (!(pend0 && !req0 && !ack0)) else begin
            failures++;
            $display("FAIL proto_req0: req0 dropped before ack0");
         end
         assert (!(pend1 && !req1 && !ack1)) else begin
            failures++;
            $display("FAIL proto_req1: req1 dropped before ack1");
         end
         pend0 <= ack0 ? 1'b0 : (req0 ? 1'b1 : pend0);
         pend1 <= ack1 ? 1'b0 : (req1 ? 1'b1 : pend1);
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       nm;
      logic        port;
      logic        we;
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic        err;
      logic [4:0]  exc;
      logic [31:0] rdata;
      logic        wr;
      logic [11:0] maddr;
      logic [31:0] wword;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string nm, input logic port, input logic we, input logic [1:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                      input logic e, input logic [4:0] exc, input logic [31:0] rd,
                      input logic wr, input logic [11:0] maddr, input logic [31:0] wword);
      vec_t v;
      v.nm = nm; v.port = port; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
      v.lat = lat; v.err = e; v.exc = exc; v.rdata = rd; v.wr = wr; v.maddr = maddr;
      v.wword = wword;
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; op0 = SW; op1 = SW;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   task automatic drive(input logic port, input logic we, input logic [1:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (!port) begin
         req0 = 1; we0 = we; op0 = op; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = 1; we1 = we; op1 = op; addr1 = addr; wdata1 = wdata;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat = 0;
      logic saw_en = 0, saw_wr = 0, g0 = 0, g1 = 0, e = 0;
      logic [4:0] x = 0;
      logic [31:0] rd = 0, wd = 0;
      logic [11:0] wa = 0;
      drive(v.port, v.we, v.op, v.addr, v.wdata);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (mem_en) saw_en = 1;
         if (mem_en && mem_we) begin
            saw_wr = 1; wd = mem_wdata; wa = mem_addr;
         end
         if (ack0 || ack1) begin
            lat = c; g0 = ack0; g1 = ack1; e = err; x = exc_code; rd = rdata;
            break;
         end
      end
      idle_inputs();
      chk({v.nm, "_lat"}, lat, v.lat);
      chk({v.nm, "_ackport"}, {g0, g1}, {~v.port, v.port});
      chk({v.nm, "_err"}, {e, x}, {v.err, v.exc});
      chk({v.nm, "_wr"}, saw_wr, v.wr);
      if (v.wr) chk({v.nm, "_wword"}, {wa, wd}, {v.maddr, v.wword});
      if (v.err) chk({v.nm, "_no_mem_en"}, saw_en, 1'b0);
      if (!v.we && !v.err) chk({v.nm, "_rdata"}, rd, v.rdata);
      step();
      chk({v.nm, "_ack_pulse"}, {ack0, ack1}, 2'b00);
   endtask

   logic [85:0] outs;
   assign outs = {ack0, ack1, err, exc_code, mem_en, mem_we, mem_addr, mem_wdata, rdata};

   initial begin
      logic sawwe;
      idle_inputs();
      reset = 0;
      load_mem = 1;
      m_old = 0; m_wd = 0; m_op = SW; m_lane = 0;
      #2;
      chk("reset_outs_async", outs, 86'h0);
      step();
      load_mem = 0;
      step();
      chk("reset_outs_held", outs, 86'h0);
      reset = 1;
      step();
      chk("idle_outs", outs, 86'h0);

      // Lane merge unit on its own.
      m_old = 32'h1122_3344; m_wd = 32'h0000_00AA; m_op = SB; m_lane = 2'd0; #1;
      chk("mrg_sb0", m_out, 32'h1122_33AA);
      m_lane = 2'd3; #1;
      chk("mrg_sb3", m_out, 32'hAA22_3344);
      m_wd = 32'h0000_BEEF; m_op = SH; m_lane = 2'd2; #1;
      chk("mrg_sh_hi", m_out, 32'hBEEF_3344);
      m_lane = 2'd0; #1;
      chk("mrg_sh_lo", m_out, 32'h1122_BEEF);

      // Simultaneous requests right after reset; port 0 re-requests at once.
      drive(1'b0, 1'b1, SW, 32'h40, 32'h1);
      drive(1'b1, 1'b1, SW, 32'h44, 32'h2);
      step();
      chk("rr_first", {ack0, ack1, mem_we, mem_addr, mem_wdata}, {3'b101, 12'h010, 32'h1});
      step();
      chk("rr_gap", {ack0, ack1, mem_en}, 3'b000);
      step();
      chk("rr_second", {ack0, ack1, mem_we, mem_addr, mem_wdata}, {3'b011, 12'h011, 32'h2});
      req1 = 0;
      step();
      chk("rr_gap2", {ack0, ack1, mem_en}, 3'b000);
      step();
      chk("rr_third", {ack0, ack1, mem_addr}, {2'b10, 12'h010});
      idle_inputs();
      step();

      //   name     port we  op  addr           wdata          lat err exc rdata          wr maddr  wword
      add("sw0",    0, 1, SW, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,          1, 12'h004, 32'hDEAD_BEEF);
      add("ld1",    1, 0, SW, 32'h0000_0010, 32'h0,         2, 0, 0, 32'hDEAD_BEEF,  0, 12'h000, 32'h0);
      add("sw1",    0, 1, SW, 32'h0000_0010, 32'h1122_3344, 1, 0, 0, 32'h0,          1, 12'h004, 32'h1122_3344);
      add("sb",     0, 1, SB, 32'h0000_0011, 32'h0000_00AA, 3, 0, 0, 32'h0,          1, 12'h004, 32'h1122_AA44);
      add("ld2",    1, 0, SW, 32'h0000_0010, 32'h0,         2, 0, 0, 32'h1122_AA44,  0, 12'h000, 32'h0);
      add("sh_hi",  0, 1, SH, 32'h0000_0012, 32'h0000_BEEF, 3, 0, 0, 32'h0,          1, 12'h004, 32'hBEEF_AA44);
      add("sh_odd", 0, 1, SH, 32'h0000_0013, 32'h0000_1234, 1, 1, 5, 32'h0,          0, 12'h000, 32'h0);
      add("ld_oor", 1, 0, SW, 32'h0000_3000, 32'h0,         1, 1, 4, 32'h0,          0, 12'h000, 32'h0);
      add("ld_mis", 1, 0, SW, 32'h0000_0012, 32'h0,         1, 1, 4, 32'h0,          0, 12'h000, 32'h0);
      add("sw_mis", 0, 1, SW, 32'h0000_2ffe, 32'h0,         1, 1, 5, 32'h0,          0, 12'h000, 32'h0);
      add("sb_end", 1, 1, SB, 32'h0000_2fff, 32'h0000_0055, 3, 0, 0, 32'h0,          1, 12'hbff, 32'h55B0_C0D0);
      add("sh_end", 0, 1, SH, 32'h0000_2ffc, 32'h0000_1234, 3, 0, 0, 32'h0,          1, 12'hbff, 32'h55B0_1234);
      add("ld_end", 1, 0, SW, 32'h0000_2ffc, 32'h0,         2, 0, 0, 32'h55B0_1234,  0, 12'h000, 32'h0);
      add("sb_oor", 0, 1, SB, 32'h0000_3000, 32'h0000_0011, 1, 1, 5, 32'h0,          0, 12'h000, 32'h0);
      add("ld_cafe",1, 0, SW, 32'h0000_0020, 32'h0,         2, 0, 0, 32'hCAFE_F00D,  0, 12'h000, 32'h0);
      add("sw_end", 1, 1, SW, 32'h0000_2ffc, 32'h0102_0304, 1, 0, 0, 32'h0,          1, 12'hbff, 32'h0102_0304);
      foreach (vq[i]) run_vec(vq[i]);

      // Reset while an sh sits in MRG must not write anything.
      drive(1'b0, 1'b1, SH, 32'h50, 32'h7777);
      step();
      chk("rst_rd", {mem_en, mem_we}, 2'b10);
      step();
      chk("rst_mrg", {mem_en, ack0}, 2'b00);
      #1;
      reset = 0;
      idle_inputs();
      #1;
      chk("rst_outs_mid", outs, 86'h0);
      sawwe = 0;
      repeat (3) begin
         step();
         if (mem_we) sawwe = 1;
      end
      chk("rst_no_we", sawwe, 1'b0);
      chk("rst_mem_kept", mem[12'h014], 32'h0);
      reset = 1;
      step();
      drive(1'b0, 1'b1, SW, 32'h50, 32'hABCD_0123);
      step();
      chk("post_rst_sw", {ack0, ack1, err, mem_we, mem_addr, mem_wdata}, {4'b1001, 12'h014, 32'hABCD_0123});
      idle_inputs();
      step();
      chk("post_rst_mem", mem[12'h014], 32'hABCD_0123);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dm_port_ctrl.md
Name: dm_port_ctrl

Overview:
- Sequencer and arbiter in front of the single-port, word-wide data memory.
- Shares the memory between two requesters: port 0 is the CPU M-stage data port, port 1 is the debug/loader port.
- Sub-word stores (sb/sh) become read-modify-write sequences.
- Illegal accesses are rejected with AdEL/AdES codes before any memory access.

Parameters:
- DM_END, 32'h0000_2fff, last valid byte address; the valid range is 0 to DM_END.
- ADDR_W, 12, memory word-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- req0 / req1  in  1  request from port 0 / port 1.
- we0 / we1  in  1  1 = store, 0 = load.
- op0 / op1  in  2  store width: 00 sw, 01 sb, 10 sh. Loads are always full-word.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  store data, right-aligned for sb/sh.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata  out  32  load result; valid only while ack0 or ack1 is high.
- err  out  1  high with ack when the access was rejected.
- exc_code  out  5  4 (AdEL) or 5 (AdES) when err=1, otherwise 0.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word index, equal to addr[13:2].
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read data, valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- Reset values: state=IDLE, last_grant=1, all registers 0. ack0, ack1, err, exc_code, mem_en, mem_we, mem_addr, mem_wdata and rdata are all 0.
- Arbitration (IDLE only):
  - Single request: that port wins.
  - Both requests: round-robin. The port not equal to last_grant wins.
  - The winner's req/we/op/addr/wdata and the port id are latched; last_grant is set to the winner.
- The requester holds req and all its fields stable until its ack. It may keep req high to start a new request; that request is re-arbitrated in the IDLE cycle after the ack.
- Checks, applied at the IDLE latch:
  - addr > DM_END is an error.
  - sw with addr[1:0] != 0 is an error.
  - sh with addr[0] != 0 is an error.
  - Load with addr[1:0] != 0 is an error.
  - A load error gives exc_code 4; a store error gives exc_code 5.
  - A rejected access never raises mem_en.
- States:
  - IDLE: wait for a request. Go to ERR if the check fails, RD if the request is a load, sb or sh, WR if it is an sw.
  - RD: mem_en=1, mem_we=0. Go to RESP for a load, MRG for sb/sh.
  - RESP: capture mem_rdata into rdata, ack the granted port, return to IDLE.
  - MRG: merge the data into the word register.
    - sb replaces byte lane addr[1:0] with wdata[7:0].
    - sh replaces half-word lane addr[1] with wdata[15:0].
    - Go to WR.
  - WR: mem_en=1, mem_we=1, mem_wdata = full word (the merged word for sb/sh). Ack the granted port, return to IDLE.
  - ERR: ack=1, err=1, exc_code set. Return to IDLE.
- Latency from the IDLE accept cycle (cycle 0) to ack:
  - sw: 1 cycle.
  - load: 2 cycles.
  - sb/sh: 3 cycles.
  - error: 1 cycle.
- Exactly one ack is high per completed transaction. The ungranted port sees no ack and stays pending.
- A request arriving while busy waits. It cannot pre-empt a transaction, including a read-modify-write.
- Asynchronous reset mid-operation returns to IDLE at once and drops any pending write; no partial merge is written.
- A req deasserted before ack is a protocol violation; its effect is undefined and the bench asserts against it.
- An sb/sh to the last word (addr 0x2ffc to 0x2fff) is legal.
- mem_addr always comes from the latched address, never from live inputs.

Decomposition:
- Shared package dm_pkg holds:
  - op codes SW=2'b00, SB=2'b01, SH=2'b10;
  - EXC_ADEL=4 and EXC_ADES=5;
  - the DM_END default;
  - the state enum IDLE/RD/RESP/MRG/WR/ERR.
- Sub-module dm_byte_merge: purely combinational. Inputs are old word, wdata, op and addr[1:0]; output is the merged word. It is unit-tested on its own.
- Arbitration stays inline in dm_port_ctrl.

Test Plan:
- Port 0 sw: addr=0x0000_0010, wdata=0xDEADBEEF -> next cycle mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, ack0=1, err=0.
- Port 0 sb: addr=0x11, wdata=0x000000AA, memory word 4 = 0x11223344 -> RD, MRG, then WR with mem_wdata=0x1122AA44, ack0 3 cycles after accept.
- Port 1 load: addr=0x10, mem_rdata=0xCAFEF00D -> ack1 plus rdata=0xCAFEF00D 2 cycles after accept.
- Both ports request in the same cycle after reset (last_grant=1) -> port 0 served first; port 1 acked on its own next transaction; no overlap in mem_en.
- Errors: sh at addr 0x13 -> ack with err=1, exc_code=5, mem_en never high. Load at 0x3000 -> exc_code=4.
- Reset pulled to 0 during MRG of an sh -> no mem_we; all outputs 0; after release, a fresh sw completes normally.
